mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Next-generation memory-access pipeline stage. It passes ALU results through to writeback and also executes loads and stores against a data memory that uses a req/ack handshake with variable latency.
- Supports byte, halfword and word accesses with a big-endian lane mapping, sign or zero extension on loads, and detection of misaligned addresses.
- Terminates a hung access with a timeout and raises a stall request to the pipeline control.
- Contains the MEM/WB register, so writeback outputs are registered.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported (byte-lane logic assumes 4 lanes).
- REG_ADDR_W, 5, destination register address width.
- MEM_ADDR_W, 32, data memory byte-address width.
- ACK_TIMEOUT, 16, maximum number of cycles in ACCESS waiting for dm_ack_i before a bus error; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wd_i  in  REG_ADDR_W  destination register from EX
- wreg_i  in  1  register write enable from EX
- wdata_i  in  DATA_W  ALU result from EX
- mem_op_i  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9–15 are treated as none
- mem_addr_i  in  MEM_ADDR_W  effective byte address
- mem_sdata_i  in  DATA_W  store data (rt)
- dm_req_o  out  1  memory request
- dm_we_o  out  1  1 = write
- dm_addr_o  out  MEM_ADDR_W  word-aligned address ({mem_addr_i[MSB:2],2'b00})
- dm_sel_o  out  4  byte enables; bit3 = bits 31:24
- dm_wdata_o  out  DATA_W  replicated store data
- dm_rdata_i  in  DATA_W  read data, valid when dm_ack_i=1
- dm_ack_i  in  1  access complete
- wd_o  out  REG_ADDR_W  to WB
- wreg_o  out  1  to WB
- wdata_o  out  DATA_W  to WB
- stall_req_o  out  1  hold IF..EX and the stage inputs
- misalign_o  out  1  one-cycle pulse: misaligned access was dropped
- bus_err_o  out  1  one-cycle pulse: access timed out
- bad_addr_o  out  MEM_ADDR_W  faulting byte address, held until the next fault

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. On a rising edge with rst=1:
  - state=IDLE and timeout counter=0
  - wd_o=0, wreg_o=0, wdata_o=0, misalign_o=0, bus_err_o=0, bad_addr_o=0
  - dm_req_o is decoded from state, so it falls after that edge.
- Reset mid-access abandons the access. Any later dm_ack_i in IDLE is ignored.
- The upstream holds all *_i inputs stable while stall_req_o=1.
- FSM states: IDLE, ACCESS.
- IDLE, mem_op none:
  - stall_req_o=0
  - at the edge, {wd_o,wreg_o,wdata_o} <= {wd_i,wreg_i,wdata_i}
  - latency is 1 cycle.
- IDLE, mem_op is a valid load/store and the address is aligned:
  - stall_req_o=1
  - next state ACCESS
  - at the edge the WB registers take a bubble (wreg_o=0, wd_o=0, wdata_o=0).
- IDLE, misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - no memory request is made and stall_req_o=0
  - at the edge: wreg_o=0, misalign_o=1 for one cycle, bad_addr_o=mem_addr_i.
- ACCESS, request signals:
  - dm_req_o=1; dm_we_o=1 for stores.
  - dm_addr_o, dm_sel_o and dm_wdata_o are held constant.
  - dm_sel_o for byte ops: addr 00→1000, 01→0100, 10→0010, 11→0001.
  - dm_sel_o for halfword ops: addr 00→1100, 10→0011.
  - dm_sel_o for word ops: 1111.
  - dm_wdata_o: SB = {4{sdata[7:0]}}; SH = {2{sdata[15:0]}}; SW = sdata.
- ACCESS, no ack:
  - stall_req_o=1; the counter increments each cycle.
- ACCESS, dm_ack_i=1:
  - stall_req_o=0 in that same cycle.
  - At the edge, load: wreg_o=wreg_i, wd_o=wd_i, wdata_o = the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - At the edge, store: wreg_o=0.
  - state goes to IDLE and the counter clears.
  - Minimum memory-op latency is 2 cycles.
- ACCESS, timeout: when the counter reaches ACK_TIMEOUT-1 without an ack:
  - stall_req_o=0 in that cycle
  - at the edge: bus_err_o=1 for one cycle, bad_addr_o=mem_addr_i, wreg_o=0, state IDLE.
  - An ack in the same cycle as the timeout wins: completion proceeds, no error.
- Default outputs: dm_* signals are 0 whenever state≠ACCESS. misalign_o and bus_err_o are 0 unless pulsed.

Test Plan:
- Pass-through: mem_op=0, wd_i=5, wreg_i=1, wdata_i=0x12345678 → next edge wd_o=5, wreg_o=1, wdata_o=0x12345678, stall_req_o never 1.
- LB/LBU lanes:
  - addr=0x103, dm_rdata_i=0x112233F4, ack on the first ACCESS cycle → dm_sel_o=0001, dm_addr_o=0x100, stall high 1 cycle; LB gives wdata_o=0xFFFFFFF4, LBU gives 0x000000F4.
  - Also cover addr 0x100/0x101/0x102.
- Stores:
  - SH addr=0x202, sdata=0xAAAABEEF → dm_we_o=1, dm_sel_o=0011, dm_wdata_o=0xBEEFBEEF, wreg_o=0 after completion.
  - SW with ack delayed 3 cycles → stall_req_o high 4 cycles total.
- Misaligned: LW addr=0x301 → dm_req_o stays 0, misalign_o pulses once, bad_addr_o=0x301, wreg_o=0, stall_req_o=0.
- Timeout:
  - LW, dm_ack_i held 0 → bus_err_o pulses after ACK_TIMEOUT cycles in ACCESS, wreg_o=0, FSM returns to IDLE.
  - Repeat with ack arriving exactly on the final cycle → normal completion, no bus_err_o.
- Reset mid-access: rst=1 during the second ACCESS cycle → after that edge dm_req_o=0, all outputs zero; a late dm_ack_i is ignored; the next pass-through works.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM pipeline stage: passes ALU results to WB and runs byte/half/word loads and
// stores over a req/ack data-memory port with big-endian lanes and an ack timeout.
module mem_lsu #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_ADDR_W  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]     mem_sdata_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [MEM_ADDR_W-1:0] dm_addr_o,
  output logic [3:0]            dm_sel_o,
  output logic [DATA_W-1:0]     dm_wdata_o,
  input  logic [DATA_W-1:0]     dm_rdata_i,
  input  logic                  dm_ack_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stall_req_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic [MEM_ADDR_W-1:0] bad_addr_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [REG_ADDR_W-1:0]   wd_reg, wd_next;
  logic                    wreg_reg, wreg_next;
  logic [DATA_W-1:0]       wdata_reg, wdata_next;
  logic                    misalign_reg, misalign_next;
  logic                    bus_err_reg, bus_err_next;
  logic [MEM_ADDR_W-1:0]   bad_addr_reg, bad_addr_next;

  logic                    we_reg;
  logic [MEM_ADDR_W-1:0]   addr_reg;
  logic [3:0]              sel_reg;
  logic [DATA_W-1:0]       sdata_reg;
  logic                    start_access;

  logic is_byte, is_half, is_word, is_store, is_load, is_mem, misaligned;
  logic [3:0]        sel_dec;
  logic [DATA_W-1:0] sdata_dec;
  logic [7:0]        rd_byte [4];
  logic [7:0]        byte_val;
  logic [15:0]       half_val;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    is_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
    is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    is_store = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
    is_load  = is_mem && !is_store;
    is_mem   = is_byte || is_half || is_word;
    misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
  end

  // Byte address 0 of a word lives in bits 31:24 (big-endian lane order).
  always_comb begin
    sel_dec   = 4'b1111;
    sdata_dec = mem_sdata_i;
    if (is_byte) begin
      sel_dec   = 4'b1000 >> mem_addr_i[1:0];
      sdata_dec = {4{mem_sdata_i[7:0]}};
    end else if (is_half) begin
      sel_dec   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      sdata_dec = {2{mem_sdata_i[15:0]}};
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = dm_rdata_i[DATA_W-1-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    byte_val = rd_byte[mem_addr_i[1:0]];
    half_val = mem_addr_i[1] ? dm_rdata_i[15:0] : dm_rdata_i[31:16];
    case (mem_op_i)
      OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_val = {24'd0, byte_val};
      OP_LH:   load_val = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_val = {16'd0, half_val};
      default: load_val = dm_rdata_i;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wd_next       = '0;
    wreg_next     = 1'b0;
    wdata_next    = '0;
    misalign_next = 1'b0;
    bus_err_next  = 1'b0;
    bad_addr_next = bad_addr_reg;
    stall_req_o   = 1'b0;
    start_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!is_mem) begin
          wd_next    = wd_i;
          wreg_next  = wreg_i;
          wdata_next = wdata_i;
        end else if (misaligned) begin
          misalign_next = 1'b1;
          bad_addr_next = mem_addr_i;
        end else begin
          stall_req_o  = 1'b1;
          start_access = 1'b1;
          state_next   = ACCESS;
          cnt_next     = '0;
        end
      end
      ACCESS: begin
        // An ack arriving in the timeout cycle still completes normally.
        if (dm_ack_i) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (is_load) begin
            wd_next    = wd_i;
            wreg_next  = wreg_i;
            wdata_next = load_val;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next    = IDLE;
          cnt_next      = '0;
          bus_err_next  = 1'b1;
          bad_addr_next = mem_addr_i;
        end else begin
          stall_req_o = 1'b1;
          cnt_next    = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wd_reg       <= '0;
      wreg_reg     <= 1'b0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      bad_addr_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      sel_reg      <= '0;
      sdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wd_reg       <= wd_next;
      wreg_reg     <= wreg_next;
      wdata_reg    <= wdata_next;
      misalign_reg <= misalign_next;
      bus_err_reg  <= bus_err_next;
      bad_addr_reg <= bad_addr_next;
      // Request fields are captured once so the bus sees them frozen during ACCESS.
      if (start_access) begin
        we_reg    <= is_store;
        addr_reg  <= {mem_addr_i[MEM_ADDR_W-1:2], 2'b00};
        sel_reg   <= sel_dec;
        sdata_reg <= sdata_dec;
      end
    end
  end

  always_comb begin
    dm_req_o   = (state_reg == ACCESS);
    dm_we_o    = dm_req_o & we_reg;
    dm_addr_o  = dm_req_o ? addr_reg  : '0;
    dm_sel_o   = dm_req_o ? sel_reg   : 4'b0000;
    dm_wdata_o = dm_req_o ? sdata_reg : '0;
  end

  assign wd_o       = wd_reg;
  assign wreg_o     = wreg_reg;
  assign wdata_o    = wdata_reg;
  assign misalign_o = misalign_reg;
  assign bus_err_o  = bus_err_reg;
  assign bad_addr_o = bad_addr_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed test-plan steps followed by random traffic, checked
// against an arithmetic model of lane selection, extension and timeout behaviour.
module tb_mem_lsu;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        dm_req_o, dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_sel_o;
  logic [31:0] dm_wdata_o;
  logic [31:0] dm_rdata_i;
  logic        dm_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, misalign_o, bus_err_o;
  logic [31:0] bad_addr_o;

  mem_lsu #(.DATA_W(32), .REG_ADDR_W(5), .MEM_ADDR_W(32), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_sel_o(dm_sel_o),
    .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_bad = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size_of(op) == 1) return 32'd1 << (3 - off);
    if (size_of(op) == 2) return 32'd3 << (2 - off);
    return 32'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
    if (size_of(op) == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (size_of(op) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int off = int'(addr % 4);
    logic [31:0] v;
    if (size_of(op) == 1) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (op == 4'd1 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size_of(op) == 2) begin
      v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
      if (op == 4'd3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic pass_through(input logic [3:0] op, input logic [4:0] wd,
                              input logic wreg, input logic [31:0] wdata);
    @(negedge clk);
    mem_op_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_addr_i = $urandom; mem_sdata_i = $urandom;
    dm_ack_i = 1'($urandom_range(0, 1));
    #1;
    check("pt_stall", 32'(stall_req_o), 32'd0);
    check("pt_req", 32'(dm_req_o), 32'd0);
    @(posedge clk); #1;
    check("pt_wd", 32'(wd_o), 32'(wd));
    check("pt_wreg", 32'(wreg_o), 32'(wreg));
    check("pt_wdata", wdata_o, wdata);
    check("pt_misalign", 32'(misalign_o), 32'd0);
    check("pt_bus_err", 32'(bus_err_o), 32'd0);
    check("pt_bad_addr", bad_addr_o, exp_bad);
    dm_ack_i = 1'b0;
  endtask

  // delay = number of ACCESS cycles without ack before the ack; delay >= T means never.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int delay,
                        input logic [4:0] wd, input logic wreg);
    int  sz = size_of(op);
    bit  mis = (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0);
    bit  is_st = (op >= 4'd6);
    bit  ack, last;
    int  stall_cnt = 1;
    int  exp_stall = (delay < T - 1) ? delay + 1 : T;
    @(negedge clk);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sd;
    wd_i = wd; wreg_i = wreg; wdata_i = $urandom; dm_ack_i = 1'b0;
    #1;
    check("idle_req", 32'(dm_req_o), 32'd0);
    if (mis) begin
      check("mis_stall", 32'(stall_req_o), 32'd0);
      @(posedge clk); #1;
      check("mis_pulse", 32'(misalign_o), 32'd1);
      check("mis_bad_addr", bad_addr_o, addr);
      check("mis_wreg", 32'(wreg_o), 32'd0);
      check("mis_req", 32'(dm_req_o), 32'd0);
      exp_bad = addr;
    end else begin
      check("start_stall", 32'(stall_req_o), 32'd1);
      for (int c = 0; c < T; c++) begin
        @(negedge clk);
        ack = (c == delay);
        dm_ack_i = ack;
        dm_rdata_i = ack ? rd : $urandom;
        #1;
        if (c == 0) begin
          check("entry_wreg", 32'(wreg_o), 32'd0);
          check("entry_wdata", wdata_o, 32'd0);
          check("entry_misalign", 32'(misalign_o), 32'd0);
          check("entry_bus_err", 32'(bus_err_o), 32'd0);
        end
        check("acc_req", 32'(dm_req_o), 32'd1);
        check("acc_we", 32'(dm_we_o), 32'(is_st));
        check("acc_addr", dm_addr_o, addr & 32'hFFFF_FFFC);
        check("acc_sel", 32'(dm_sel_o), exp_sel(op, addr));
        if (is_st) check("acc_wdata", dm_wdata_o, exp_wdata(op, sd));
        last = ack || (c == T - 1);
        check("acc_stall", 32'(stall_req_o), last ? 32'd0 : 32'd1);
        if (stall_req_o) stall_cnt++;
        if (last) begin
          @(posedge clk); #1;
          if (ack) begin
            check("done_bus_err", 32'(bus_err_o), 32'd0);
            if (is_st) begin
              check("st_wreg", 32'(wreg_o), 32'd0);
            end else begin
              check("ld_wreg", 32'(wreg_o), 32'(wreg));
              check("ld_wd", 32'(wd_o), 32'(wd));
              check("ld_wdata", wdata_o, exp_load(op, addr, rd));
            end
          end else begin
            check("to_bus_err", 32'(bus_err_o), 32'd1);
            check("to_bad_addr", bad_addr_o, addr);
            check("to_wreg", 32'(wreg_o), 32'd0);
            exp_bad = addr;
          end
          break;
        end
        @(posedge clk);
      end
      check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    end
    @(negedge clk);
    mem_op_i = 4'd0; dm_ack_i = 1'b0;
    #1;
    check("after_req", 32'(dm_req_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_op_i = '0;
    mem_addr_i = '0; mem_sdata_i = '0; dm_rdata_i = '0; dm_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wd", 32'(wd_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    check("rst_bad_addr", bad_addr_o, 32'd0);
    check("rst_req", 32'(dm_req_o), 32'd0);
    rst = 1'b0;

    pass_through(4'd0, 5'd5, 1'b1, 32'h1234_5678);

    do_mem(4'd1, 32'h103, 32'd0, 32'h1122_33F4, 0, 5'd7, 1'b1);
    check("lb_103_const", wdata_o, 32'hFFFF_FFF4);
    do_mem(4'd2, 32'h103, 32'd0, 32'h1122_33F4, 0, 5'd7, 1'b1);
    check("lbu_103_const", wdata_o, 32'h0000_00F4);
    for (int a = 0; a < 3; a++) begin
      do_mem(4'd1, 32'h100 + 32'(a), 32'd0, 32'h8192_A3F4, 0, 5'd3, 1'b1);
      do_mem(4'd2, 32'h100 + 32'(a), 32'd0, 32'h8192_A3F4, 1, 5'd4, 1'b1);
    end
    do_mem(4'd3, 32'h102, 32'd0, 32'h1234_9ABC, 0, 5'd9, 1'b1);
    check("lh_102_const", wdata_o, 32'hFFFF_9ABC);

    do_mem(4'd7, 32'h202, 32'hAAAA_BEEF, 32'd0, 0, 5'd1, 1'b1);
    do_mem(4'd8, 32'h204, 32'hCAFE_F00D, 32'd0, 3, 5'd1, 1'b1);

    do_mem(4'd5, 32'h301, 32'd0, 32'd0, 0, 5'd2, 1'b1);
    pass_through(4'd0, 5'd6, 1'b1, 32'h0BAD_F00D);

    do_mem(4'd5, 32'h400, 32'd0, 32'd0, T, 5'd2, 1'b1);
    do_mem(4'd5, 32'h404, 32'd0, 32'h5566_7788, T - 1, 5'd2, 1'b1);
    check("ack_last_const", wdata_o, 32'h5566_7788);

    // Reset during the second ACCESS cycle, then a stray ack while idle.
    @(negedge clk);
    mem_op_i = 4'd5; mem_addr_i = 32'h500; wd_i = 5'd8; wreg_i = 1'b1; dm_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("mid_req", 32'(dm_req_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_req", 32'(dm_req_o), 32'd0);
    check("mrst_wreg", 32'(wreg_o), 32'd0);
    check("mrst_bus_err", 32'(bus_err_o), 32'd0);
    check("mrst_bad_addr", bad_addr_o, 32'd0);
    exp_bad = 32'd0;
    @(negedge clk);
    rst = 1'b0; mem_op_i = 4'd0; dm_ack_i = 1'b1; dm_rdata_i = 32'hDEAD_BEEF;
    #1 check("late_ack_req", 32'(dm_req_o), 32'd0);
    dm_ack_i = 1'b0;
    pass_through(4'd0, 5'd11, 1'b1, 32'hA5A5_0001);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op = 4'($urandom_range(0, 15));
      int          r = $urandom_range(0, 9);
      int          dly = (r == 9) ? T : (r == 8) ? T - 1 : r % 4;
      if (size_of(op) == 0)
        pass_through(op, 5'($urandom), 1'($urandom), $urandom);
      else
        do_mem(op, $urandom, $urandom, $urandom, dly, 5'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
